dot_product_feeder: RTL
=======================

Name: dot_product_feeder

Overview:
- Producer end of the scalar dot-product stream: accepts two full vectors in parallel and serialises them one element pair per cycle with a valid strobe.
- Output format matches what the streaming dot-product consumer expects on its input_valid/A_vec/B_vec inputs.
- Waits for the consumer's output_valid/result, captures the result and reports completion.
- Sits between a parallel vector source (register file or DMA staging) and the streaming dot-product engine.

Parameters:
- WIDTH, 8, element width in bits.
- N, 4, elements per vector (N >= 2).
- TIMEOUT, 16, drain watchdog limit in cycles. Used only with FEEDER_TIMEOUT_EN.
- RW (localparam), 2*WIDTH + $clog2(N), result width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- load_valid  in  1  A_flat/B_flat are valid.
- load_ready  out  1  feeder can accept a vector pair.
- A_flat  in  WIDTH*N  vector A; element i is at bits [i*WIDTH +: WIDTH].
- B_flat  in  WIDTH*N  vector B, same packing as A_flat.
- out_valid  out  1  element strobe to the consumer's input_valid.
- A_out  out  WIDTH  current A element.
- B_out  out  WIDTH  current B element.
- res_valid  in  1  consumer output_valid.
- res_in  in  RW  consumer result.
- result  out  RW  last captured result.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  drain watchdog fired.

Behaviour:
- Reset (rst high at posedge):
  - state = IDLE; out_valid = 0; A_out = B_out = 0; result = 0; done = 0; timeout_err = 0; element index = 0.
  - load_ready = 1 from the first cycle after reset is released.
  - rst overrides all other inputs in any state, including mid-stream; the partial vector is discarded and no done pulse is issued.
- All outputs are registered. load_ready is a decode of state: 1 only in IDLE.
- Handshake: a load is accepted at a posedge where load_valid && load_ready. A_flat and B_flat are copied into internal shift registers, so the source may change them on the next cycle.
- States:
  - IDLE: wait for an accepted load, then go to STREAM.
  - STREAM: drive one element pair per cycle for N consecutive cycles, then go to DRAIN.
  - DRAIN: wait for res_valid, then return to IDLE.
- Stream timing, load accepted at edge T:
  - out_valid = 1 during cycles T+1 .. T+N, with A_out/B_out = element 0 .. N-1 in index order. There are no gaps.
  - At edge T+N+1, out_valid = 0 and A_out = B_out = 0; state = DRAIN.
- Element index counter: 0 .. N-1. The transition to DRAIN happens when index == N-1; the counter wraps to 0.
- DRAIN:
  - On the first posedge with res_valid = 1: result <= res_in, state <= IDLE, and done = 1 for exactly the following cycle.
  - load_ready is 1 in that same cycle, so a back-to-back load accepted while done = 1 starts streaming on the next cycle.
- res_valid outside DRAIN is ignored; result is unchanged.
- load_valid outside IDLE is ignored; nothing is queued.
- result holds its value until the next capture or rst.
- timeout_err is held at 0 when FEEDER_TIMEOUT_EN is not defined.

Optional Feature:
- Macro: FEEDER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in DRAIN, cleared on entry to DRAIN.
  - If it reaches TIMEOUT with no res_valid, the FSM returns to IDLE, done pulses for one cycle, result is left unchanged, and timeout_err is set.
  - timeout_err is sticky until the next accepted load or rst.
  - If res_valid arrives on the same cycle the limit is reached, res_valid wins: normal capture, no error.
- Not defined: DRAIN waits indefinitely; no counter logic is synthesised; timeout_err is tied to 0.

Test Plan:
1. rst high for 3 cycles, then low -> load_ready = 1, out_valid = 0, done = 0, result = 0, A_out = B_out = 0.
2. Load A = {4,3,2,1} and B = {2,0,1,10} (packed MSB first), then pulse res_valid with res_in = 20 two cycles after the stream ends:
   - out_valid high for exactly 4 cycles;
   - A_out = 1, 2, 3, 4 and B_out = 10, 1, 0, 2;
   - load_ready = 0 throughout the stream and drain;
   - result = 20 and a single done pulse.
3. load_valid held high continuously with A = {1,1,1,1} and B = {1,1,1,1}; return res_in = 4 -> one load accepted only; the second load is accepted in the done cycle; second stream starts on the next cycle with no gap.
4. res_valid pulse with res_in = 99 during STREAM -> ignored, result still 0; a later res_in = 1020 in DRAIN (A = {4{255}}, B = {4{1}}) -> result = 1020.
5. rst asserted after 2 streamed elements -> on the next cycle out_valid = 0, load_ready = 1, result = 0, and no done pulse.
6. No res_valid after the stream:
   - With FEEDER_TIMEOUT_EN and TIMEOUT = 16: after 16 DRAIN cycles, done = 1, timeout_err = 1, result unchanged; the next load clears timeout_err.
   - Without the macro: load_ready stays 0 for 100 cycles.

Source files
------------

// File: rtl/dot_product_feeder.sv
// Serialises a loaded A/B vector pair one element per cycle into a streaming dot-product engine and captures its result.
// Optional drain watchdog enabled by defining FEEDER_TIMEOUT_EN.
module dot_product_feeder #(
    parameter int WIDTH   = 8,
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    localparam int RW     = 2*WIDTH + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WIDTH*N-1:0]   A_flat,
    input  logic [WIDTH*N-1:0]   B_flat,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     A_out,
    output logic [WIDTH-1:0]     B_out,
    input  logic                 res_valid,
    input  logic [RW-1:0]        res_in,
    output logic [RW-1:0]        result,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int IW = $clog2(N);

    if (N < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("dot_product_feeder: N must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [WIDTH*N-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     a_out_q, a_out_d, b_out_q, b_out_d;
    logic [RW-1:0]        result_q, result_d;
    logic                 done_q, done_d;
`ifdef FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 terr_q, terr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            cnt_q       <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            result_q    <= result_d;
            done_q      <= done_d;
`ifdef FEEDER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        a_out_d     = '0;
        b_out_d     = '0;
        result_d    = result_q;
        done_d      = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        cnt_d       = cnt_q;
        terr_d      = terr_q;
`endif
        case (state_q)
            IDLE: begin
                // Element 0 goes straight to the output; the shifters hold the rest.
                if (load_valid) begin
                    state_d     = STREAM;
                    out_valid_d = 1'b1;
                    a_out_d     = A_flat[WIDTH-1:0];
                    b_out_d     = B_flat[WIDTH-1:0];
                    a_sr_d      = A_flat >> WIDTH;
                    b_sr_d      = B_flat >> WIDTH;
                    idx_d       = '0;
`ifdef FEEDER_TIMEOUT_EN
                    terr_d      = 1'b0;
`endif
                end
            end
            STREAM: begin
                if (idx_q == IW'(N - 1)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
`ifdef FEEDER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    out_valid_d = 1'b1;
                    a_out_d     = a_sr_q[WIDTH-1:0];
                    b_out_d     = b_sr_q[WIDTH-1:0];
                    a_sr_d      = a_sr_q >> WIDTH;
                    b_sr_d      = b_sr_q >> WIDTH;
                    idx_d       = idx_q + IW'(1);
                end
            end
            DRAIN: begin
                if (res_valid) begin
                    result_d = res_in;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign A_out      = a_out_q;
    assign B_out      = b_out_q;
    assign result     = result_q;
    assign done       = done_q;
`ifdef FEEDER_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
